// File: rtl/serial_word_sender_mod_n_if.sv
// Load and serial-bit handshake bundle for the serial word sender.
// The slave side is the sender; the master side feeds words and consumes bits.
interface serial_word_sender_mod_n_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             bit_valid;
  logic             bit_ready;
  logic             bit_out;
  logic             bit_last;

  modport master (
    output load_valid, load_data, bit_ready,
    input  load_ready, bit_valid, bit_out, bit_last
  );

  modport slave (
    input  load_valid, load_data, bit_ready,
    output load_ready, bit_valid, bit_out, bit_last
  );
endinterface

// File: rtl/serial_word_sender_mod_n.sv
// Parallel-to-serial word sender, MSB first, tracking the running remainder
// mod DIVISOR of the bits already sent as a reference for the receiver.
module serial_word_sender_mod_n #(
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 5,
  localparam int RW = $clog2(DIVISOR),
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_word_sender_mod_n_if.slave sif,
  output logic                      busy,
  output logic [RW-1:0]             rem,
  output logic                      div_flag
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    rem_q;
  logic             load_ready_q;
  logic             bit_valid_q;
  logic             bit_last_q;
  logic             busy_q;
  logic             div_q;

  // 2*rem+bit is at most 2*DIVISOR-1, so one conditional subtract suffices.
  logic [RW:0]   rem2;
  logic [RW-1:0] rem_nxt;
  always_comb begin
    rem2 = {rem_q, 1'b0} | (RW+1)'(sreg[WIDTH-1]);
    if (rem2 >= (RW+1)'(DIVISOR))
      rem2 = rem2 - (RW+1)'(DIVISOR);
    rem_nxt = rem2[RW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      sreg         <= '0;
      cnt          <= '0;
      rem_q        <= '0;
      load_ready_q <= 1'b1;
      bit_valid_q  <= 1'b0;
      bit_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      div_q        <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (sif.load_valid) begin
            state        <= SEND;
            sreg         <= sif.load_data;
            cnt          <= CW'(WIDTH-1);
            rem_q        <= '0;
            div_q        <= 1'b1;
            load_ready_q <= 1'b0;
            bit_valid_q  <= 1'b1;
            bit_last_q   <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        SEND: begin
          // Without bit_ready everything holds; a stall never drops bit_valid.
          if (sif.bit_ready) begin
            sreg  <= sreg << 1;
            rem_q <= rem_nxt;
            div_q <= (rem_nxt == '0);
            if (bit_last_q) begin
              state        <= IDLE;
              load_ready_q <= 1'b1;
              bit_valid_q  <= 1'b0;
              bit_last_q   <= 1'b0;
              busy_q       <= 1'b0;
            end else begin
              cnt        <= cnt - CW'(1);
              bit_last_q <= (cnt == CW'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sif.load_ready = load_ready_q;
  assign sif.bit_valid  = bit_valid_q;
  assign sif.bit_out    = sreg[WIDTH-1];
  assign sif.bit_last   = bit_last_q;
  assign busy           = busy_q;
  assign rem            = rem_q;
  assign div_flag       = div_q;

endmodule

// File: tb/tb_serial_word_sender_mod_n.sv
// Directed bench for serial_word_sender_mod_n (WIDTH=8, DIVISOR=5).
module tb_serial_word_sender_mod_n;
  logic       clk;
  logic       rst;
  logic       busy;
  logic [2:0] rem;
  logic       div_flag;
  int         n_vec;
  int         n_err;

  serial_word_sender_mod_n_if #(.WIDTH(8)) sif ();

  serial_word_sender_mod_n #(.WIDTH(8), .DIVISOR(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .sif      (sif),
    .busy     (busy),
    .rem      (rem),
    .div_flag (div_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_load(input logic [7:0] w);
    @(negedge clk);
    sif.load_valid = 1'b1;
    sif.load_data  = w;
    n_vec++;
    if (sif.load_ready !== 1'b1) begin
      n_err++; $display("FAIL load_ready_before_load: got %b want 1", sif.load_ready);
    end
    @(posedge clk);
    @(negedge clk);
    sif.load_valid = 1'b0;
    n_vec++;
    if (sif.bit_valid !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL first_bit_valid: bit_valid=%b busy=%b want 1/1", sif.bit_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    sif.load_valid = 1'b0;
    sif.load_data  = '0;
    sif.bit_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (sif.load_ready !== 1'b1 || sif.bit_valid !== 1'b0 || rem !== 3'd0 || div_flag !== 1'b1) begin
      n_err++; $display("FAIL reset_state: ready=%b valid=%b rem=%0d div=%b want 1/0/0/1",
                        sif.load_ready, sif.bit_valid, rem, div_flag);
    end
    n_vec++;
    if (sif.bit_out !== 1'b0 || sif.bit_last !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_outs: bit_out=%b last=%b busy=%b want 0/0/0",
                        sif.bit_out, sif.bit_last, busy);
    end
    rst = 1'b1;
  endtask

  task automatic test_word25();
    logic [7:0]      bits;
    logic [7:0][2:0] rt;
    bits = 8'b00011001;
    rt   = {3'd0, 3'd2, 3'd1, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0};
    do_load(8'd25);
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (sif.bit_out !== bits[7-i] || sif.bit_last !== (i == 7)) begin
        n_err++; $display("FAIL w25_bit%0d: bit=%b last=%b want %b/%b", i, sif.bit_out, sif.bit_last, bits[7-i], (i == 7));
      end
      @(posedge clk); #1;
      n_vec++;
      if (rem !== rt[i]) begin
        n_err++; $display("FAIL w25_rem%0d: got %0d want %0d", i, rem, rt[i]);
      end
      @(negedge clk);
    end
    n_vec++;
    if (sif.bit_valid !== 1'b0 || sif.load_ready !== 1'b1 || div_flag !== 1'b1 || rem !== 3'd0) begin
      n_err++; $display("FAIL w25_end: valid=%b ready=%b div=%b rem=%0d want 0/1/1/0",
                        sif.bit_valid, sif.load_ready, div_flag, rem);
    end
  endtask

  task automatic test_27_and_0();
    logic [7:0] bits;
    bits = 8'b00011011;
    do_load(8'd27);
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (sif.bit_out !== bits[7-i]) begin
        n_err++; $display("FAIL w27_bit%0d: got %b want %b", i, sif.bit_out, bits[7-i]);
      end
      @(negedge clk);
    end
    n_vec++;
    if (rem !== 3'd2 || div_flag !== 1'b0) begin
      n_err++; $display("FAIL w27_end: rem=%0d div=%b want 2/0", rem, div_flag);
    end
    do_load(8'd0);
    n_vec++;
    if (rem !== 3'd0 || div_flag !== 1'b1) begin
      n_err++; $display("FAIL w0_load_clear: rem=%0d div=%b want 0/1", rem, div_flag);
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (sif.bit_out !== 1'b0 || sif.bit_valid !== 1'b1) begin
        n_err++; $display("FAIL w0_bit%0d: bit=%b valid=%b want 0/1", i, sif.bit_out, sif.bit_valid);
      end
      @(negedge clk);
    end
    n_vec++;
    if (rem !== 3'd0 || div_flag !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL w0_end: rem=%0d div=%b busy=%b want 0/1/0", rem, div_flag, busy);
    end
  endtask

  task automatic test_stall();
    logic [7:0]      bits;
    logic [7:0][2:0] rt;
    bits = 8'b10100101;
    rt   = {3'd0, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd2, 3'd1};
    do_load(8'hA5);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        sif.bit_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(posedge clk);
          @(negedge clk);
          n_vec++;
          if (sif.bit_out !== 1'b0 || sif.bit_valid !== 1'b1 || sif.bit_last !== 1'b0 || rem !== 3'd0) begin
            n_err++; $display("FAIL stall%0d: bit=%b valid=%b last=%b rem=%0d want 0/1/0/0",
                              s, sif.bit_out, sif.bit_valid, sif.bit_last, rem);
          end
        end
        sif.bit_ready = 1'b1;
      end
      n_vec++;
      if (sif.bit_out !== bits[7-i] || sif.bit_last !== (i == 7)) begin
        n_err++; $display("FAIL a5_bit%0d: bit=%b last=%b want %b/%b", i, sif.bit_out, sif.bit_last, bits[7-i], (i == 7));
      end
      @(posedge clk); #1;
      n_vec++;
      if (rem !== rt[i]) begin
        n_err++; $display("FAIL a5_rem%0d: got %0d want %0d", i, rem, rt[i]);
      end
      @(negedge clk);
    end
    n_vec++;
    if (div_flag !== 1'b1 || sif.bit_valid !== 1'b0) begin
      n_err++; $display("FAIL a5_end: div=%b valid=%b want 1/0", div_flag, sif.bit_valid);
    end
  endtask

  task automatic test_ignore_load();
    logic [7:0] bits;
    bits = 8'b00011001;
    do_load(8'd25);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        sif.load_valid = 1'b1;
        sif.load_data  = 8'hFF;
      end
      if (i == 3) sif.load_valid = 1'b0;
      if (i == 7) begin
        n_vec++;
        if (sif.load_ready !== 1'b0) begin
          n_err++; $display("FAIL ign_ready_last: got %b want 0", sif.load_ready);
        end
      end
      n_vec++;
      if (sif.bit_out !== bits[7-i]) begin
        n_err++; $display("FAIL ign_bit%0d: got %b want %b", i, sif.bit_out, bits[7-i]);
      end
      @(negedge clk);
    end
    n_vec++;
    if (sif.load_ready !== 1'b1 || sif.bit_valid !== 1'b0 || rem !== 3'd0) begin
      n_err++; $display("FAIL ign_end: ready=%b valid=%b rem=%0d want 1/0/0", sif.load_ready, sif.bit_valid, rem);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (sif.bit_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL ign_not_stored: valid=%b busy=%b want 0/0", sif.bit_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] bits;
    do_load(8'd200);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (sif.load_ready !== 1'b1 || sif.bit_valid !== 1'b0 || busy !== 1'b0 || rem !== 3'd0 || div_flag !== 1'b1) begin
      n_err++; $display("FAIL mid_reset: ready=%b valid=%b busy=%b rem=%0d div=%b want 1/0/0/0/1",
                        sif.load_ready, sif.bit_valid, busy, rem, div_flag);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (sif.bit_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_no_resume: valid=%b want 0", sif.bit_valid);
    end
    bits = 8'b00001010;
    do_load(8'd10);
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (sif.bit_out !== bits[7-i] || sif.bit_last !== (i == 7)) begin
        n_err++; $display("FAIL w10_bit%0d: bit=%b last=%b want %b/%b", i, sif.bit_out, sif.bit_last, bits[7-i], (i == 7));
      end
      @(negedge clk);
    end
    n_vec++;
    if (rem !== 3'd0 || div_flag !== 1'b1) begin
      n_err++; $display("FAIL w10_end: rem=%0d div=%b want 0/1", rem, div_flag);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_word25();
    test_27_and_0();
    test_stall();
    test_ignore_load();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
